// File: rtl/pix_pack_pkg.sv
// pix_pack_pkg: shared FSM states, format-decode constants and slot counts for pix_pack_ctrl.
package pix_pack_pkg;
  typedef enum logic [2:0] {WAIT_LOW, IDLE, SKIP, FRAME, FLUSH, FRAME_END} state_e;
  localparam logic [5:0] FMT8_A = 6'b010001;
  localparam logic [5:0] FMT8_B = 6'b011000;
  localparam int SLOTS8 = 4;
  localparam int SLOTS10 = 2;
  function automatic logic is_fmt8(input logic [5:0] sel);
    return sel == FMT8_A || sel == FMT8_B;
  endfunction
endpackage

// File: rtl/pix_pack_word.sv
// pix_pack_word: packing register and slot index; word_o already includes the pixel being written.
module pix_pack_word
  import pix_pack_pkg::*;
#(
  parameter int DATA_IN_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode8_i,
  input  logic [DATA_IN_WIDTH-1:0] pix_i,
  input  logic                     wr_i,
  input  logic                     clr_i,
  output logic [31:0]              word_o,
  output logic                     full_o,
  output logic                     pend_o
);
  logic [1:0] idx_q, last;
  logic [31:0] word_q, ins;
  logic [7:0] p8;
  logic [15:0] p16;
  assign p8 = pix_i[DATA_IN_WIDTH-1 -: 8];
  assign p16 = 16'(pix_i);
  assign last = mode8_i ? 2'(SLOTS8 - 1) : 2'(SLOTS10 - 1);
  assign ins = mode8_i ? {24'd0, p8} << {idx_q, 3'd0} : {16'd0, p16} << {idx_q[0], 4'd0};
  assign word_o = wr_i ? word_q | ins : word_q;
  assign full_o = wr_i && idx_q == last;
  assign pend_o = idx_q != 2'd0;
  // A completed word restarts from zero so a later partial flush has empty upper slots.
  always_ff @(posedge clk) begin
    if (reset || clr_i || full_o) begin
      word_q <= '0;
      idx_q <= '0;
    end else if (wr_i) begin
      word_q <= word_o;
      idx_q <= idx_q + 2'd1;
    end
  end
endmodule

// File: rtl/pix_pack_ctrl.sv
// pix_pack_ctrl: frame-level pixel packer (fval/lval in, 32-bit words out).
// Optional per-frame statistics outputs are enabled with PIX_PACK_STAT_EN.
module pix_pack_ctrl
  import pix_pack_pkg::*;
#(
  parameter int REG_WD = 32,
  parameter int DATA_IN_WIDTH = 10,
  parameter int DATA_OUT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_pack_en,
  input  logic [REG_WD-1:0]         iv_pixel_format,
  input  logic                      i_fval,
  input  logic                      i_lval,
  input  logic [DATA_IN_WIDTH-1:0]  iv_pix_data,
  output logic                      o_fval,
  output logic                      o_lval,
  output logic [DATA_OUT_WIDTH-1:0] ov_pix_data,
  output logic                      o_busy
`ifdef PIX_PACK_STAT_EN
  ,
  output logic [15:0]               ov_word_cnt,
  output logic [15:0]               ov_flush_cnt,
  output logic [15:0]               ov_err_cnt
`endif
);
  state_e state_q, state_d;
  logic fval_q, mode8_q, en_q, pend_q;
  logic rise, wr, clr, full, pix_pend, lval_d;
  logic [31:0] word;
  assign rise = !fval_q && i_fval;
  assign wr = state_q == FRAME && i_fval && i_lval;
  assign lval_d = full || (state_q == FRAME && state_d == FLUSH);
  pix_pack_word #(.DATA_IN_WIDTH(DATA_IN_WIDTH)) u_word (
    .clk(clk),
    .reset(reset),
    .mode8_i(mode8_q),
    .pix_i(iv_pix_data),
    .wr_i(wr),
    .clr_i(clr),
    .word_o(word),
    .full_o(full),
    .pend_o(pix_pend)
  );
  // pend_q carries a frame start seen during FRAME_END, so a 1-cycle fval gap is not lost.
  always_comb begin
    state_d = state_q;
    clr = 1'b0;
    case (state_q)
      WAIT_LOW: state_d = i_fval ? WAIT_LOW : IDLE;
      IDLE: begin
        clr = 1'b1;
        if (rise || pend_q) state_d = (rise ? i_pack_en : en_q) ? FRAME : SKIP;
      end
      SKIP: state_d = i_fval ? SKIP : IDLE;
      FRAME: begin
        if (!(i_fval && i_lval) && pix_pend) state_d = FLUSH;
        else if (!i_fval) state_d = FRAME_END;
      end
      FLUSH: begin
        clr = 1'b1;
        state_d = i_fval ? FRAME : FRAME_END;
      end
      FRAME_END: state_d = IDLE;
      default: state_d = WAIT_LOW;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_LOW;
      fval_q <= 1'b0;
      mode8_q <= 1'b0;
      en_q <= 1'b0;
      pend_q <= 1'b0;
      o_fval <= 1'b0;
      o_lval <= 1'b0;
      ov_pix_data <= '0;
      o_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      fval_q <= i_fval;
      if (rise && (state_q == IDLE || state_q == FRAME_END)) begin
        mode8_q <= is_fmt8({iv_pixel_format[20], iv_pixel_format[19], iv_pixel_format[3:0]});
        en_q <= i_pack_en;
      end
      pend_q <= rise && state_q == FRAME_END;
      o_fval <= state_d inside {FRAME, FLUSH, FRAME_END};
      o_lval <= lval_d;
      ov_pix_data <= lval_d ? word : '0;
      o_busy <= state_d != IDLE;
    end
  end
`ifdef PIX_PACK_STAT_EN
  logic [15:0] words_q, flush_q, err_q, words_d, flush_d, err_d;
  logic start;
  assign start = state_q == IDLE && state_d != IDLE;
  assign words_d = words_q + 16'(lval_d);
  assign flush_d = flush_q + 16'(state_q == FRAME && state_d == FLUSH);
  assign err_d = err_q + 16'(state_q == FRAME && i_lval && !i_fval);
  always_ff @(posedge clk) begin
    if (reset || start) begin
      words_q <= '0;
      flush_q <= '0;
      err_q <= '0;
      ov_word_cnt <= '0;
      ov_flush_cnt <= '0;
      ov_err_cnt <= '0;
    end else begin
      words_q <= words_d;
      flush_q <= flush_d;
      err_q <= err_d;
      if (state_d == FRAME_END) begin
        ov_word_cnt <= words_d;
        ov_flush_cnt <= flush_d;
        ov_err_cnt <= err_d;
      end
    end
  end
`endif
endmodule

// File: tb/tb_pix_pack_ctrl.sv
// tb_pix_pack_ctrl: table-driven directed bench for pix_pack_ctrl.
module tb_pix_pack_ctrl;
  localparam logic [31:0] M8 = 32'h01080001;
  localparam logic [31:0] M10 = 32'h01100003;
  localparam logic [31:0] B10 = 32'h0110000C;
  logic clk = 1'b0;
  logic reset, i_pack_en, i_fval, i_lval, o_fval, o_lval, o_busy;
  logic [31:0] iv_pixel_format, ov_pix_data;
  logic [9:0] iv_pix_data;
`ifdef PIX_PACK_STAT_EN
  logic [15:0] ov_word_cnt, ov_flush_cnt, ov_err_cnt;
`endif
  typedef struct {
    logic rst, fv, lv, en;
    logic [31:0] fmt;
    logic [9:0] pix;
    logic efv, elv, ebusy;
    logic [31:0] edata;
  } vec_t;
  vec_t tbl[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [9:0] pe[4] = '{10'h100, 10'h200, 10'h300, 10'h3FC};

  always #5 clk = ~clk;

  pix_pack_ctrl dut (
    .clk(clk),
    .reset(reset),
    .i_pack_en(i_pack_en),
    .iv_pixel_format(iv_pixel_format),
    .i_fval(i_fval),
    .i_lval(i_lval),
    .iv_pix_data(iv_pix_data),
    .o_fval(o_fval),
    .o_lval(o_lval),
    .ov_pix_data(ov_pix_data),
    .o_busy(o_busy)
`ifdef PIX_PACK_STAT_EN
    ,
    .ov_word_cnt(ov_word_cnt),
    .ov_flush_cnt(ov_flush_cnt),
    .ov_err_cnt(ov_err_cnt)
`endif
  );

  task automatic v(input logic r, fv, lv, en, input logic [31:0] fmt, input logic [9:0] pix,
                   input logic efv, elv, ebusy, input logic [31:0] edata);
    tbl.push_back('{r, fv, lv, en, fmt, pix, efv, elv, ebusy, edata});
  endtask

  task automatic step(input logic r, fv, lv, en, input logic [31:0] fmt, input logic [9:0] pix);
    reset = r;
    i_fval = fv;
    i_lval = lv;
    i_pack_en = en;
    iv_pixel_format = fmt;
    iv_pix_data = pix;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    // reset, then WAIT_LOW -> IDLE
    v(1, 0, 0, 1, M8, 0, 0, 0, 0, 0);
    v(1, 0, 0, 1, M8, 0, 0, 0, 0, 0);
    v(0, 0, 0, 1, M8, 0, 0, 0, 0, 0);
    // Mono8, 8 pixels 4k
    v(0, 1, 0, 1, M8, 0, 1, 0, 1, 0);
    for (int k = 1; k <= 8; k++)
      v(0, 1, 1, 1, M8, 10'(4 * k), 1, k % 4 == 0, 1, k == 4 ? 32'h04030201 : 32'h08070605);
    v(0, 1, 0, 1, M8, 0, 1, 0, 1, 0);
    v(0, 0, 0, 1, M8, 0, 1, 0, 1, 0);
    v(0, 0, 0, 1, M8, 0, 0, 0, 0, 0);
    // Mono10 with line-end flush
    v(0, 1, 0, 1, M10, 0, 1, 0, 1, 0);
    v(0, 1, 1, 1, M10, 10'h3FF, 1, 0, 1, 0);
    v(0, 1, 1, 1, M10, 10'h155, 1, 1, 1, 32'h015503FF);
    v(0, 1, 1, 1, M10, 10'h2AA, 1, 0, 1, 0);
    v(0, 1, 0, 1, M10, 0, 1, 1, 1, 32'h000002AA);
    v(0, 1, 0, 1, M10, 0, 1, 0, 1, 0);
    v(0, 0, 0, 1, M10, 0, 1, 0, 1, 0);
    v(0, 0, 0, 1, M10, 0, 0, 0, 0, 0);
    // enable low at frame start, raised mid-frame: frame skipped
    v(0, 1, 0, 0, M8, 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) v(0, 1, 1, 1, M8, pe[k], 0, 0, 1, 0);
    v(0, 0, 0, 1, M8, 0, 0, 0, 0, 0);
    v(0, 1, 0, 1, M8, 0, 1, 0, 1, 0);
    for (int k = 0; k < 4; k++) v(0, 1, 1, 1, M8, pe[k], 1, k == 3, 1, 32'hFFC08040);
    v(0, 1, 0, 1, M8, 0, 1, 0, 1, 0);
    v(0, 0, 0, 1, M8, 0, 1, 0, 1, 0);
    v(0, 0, 0, 1, M8, 0, 0, 0, 0, 0);
    // format change mid-frame, then back-to-back frame in BayerGR10
    v(0, 1, 0, 1, M8, 0, 1, 0, 1, 0);
    for (int k = 1; k <= 4; k++)
      v(0, 1, 1, 1, k <= 2 ? M8 : B10, 10'(4 * k), 1, k == 4, 1, 32'h04030201);
    v(0, 1, 0, 1, B10, 0, 1, 0, 1, 0);
    v(0, 0, 0, 1, B10, 0, 1, 0, 1, 0);
    v(0, 1, 0, 1, B10, 0, 0, 0, 0, 0);
    v(0, 1, 0, 1, B10, 0, 1, 0, 1, 0);
    v(0, 1, 1, 1, B10, 10'h123, 1, 0, 1, 0);
    v(0, 1, 1, 1, B10, 10'h0AB, 1, 1, 1, 32'h00AB0123);
    v(0, 1, 0, 1, B10, 0, 1, 0, 1, 0);
    v(0, 0, 0, 1, B10, 0, 1, 0, 1, 0);
    v(0, 0, 0, 1, B10, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].fv, tbl[i].lv, tbl[i].en, tbl[i].fmt, tbl[i].pix);
      chk($sformatf("row%0d fval", i), 32'(o_fval), 32'(tbl[i].efv));
      chk($sformatf("row%0d lval", i), 32'(o_lval), 32'(tbl[i].elv));
      chk($sformatf("row%0d busy", i), 32'(o_busy), 32'(tbl[i].ebusy));
      if (tbl[i].elv) chk($sformatf("row%0d data", i), ov_pix_data, tbl[i].edata);
    end

    // reset after 3 pixels of a Mono8 line
    step(0, 1, 0, 1, M8, 0);
    chk("rst_pre fval", 32'(o_fval), 1);
    for (int k = 1; k <= 3; k++) begin
      step(0, 1, 1, 1, M8, 10'(4 * k));
      chk("rst_pre lval", 32'(o_lval), 0);
    end
    step(1, 1, 1, 1, M8, 10'h010);
    chk("rst fval", 32'(o_fval), 0);
    chk("rst lval", 32'(o_lval), 0);
    chk("rst busy", 32'(o_busy), 0);
    chk("rst data", ov_pix_data, 0);
    for (int k = 5; k <= 9; k++) begin
      step(0, 1, 1, 1, M8, 10'(4 * k));
      chk("rst_mid fval", 32'(o_fval), 0);
      chk("rst_mid lval", 32'(o_lval), 0);
    end
    step(0, 1, 0, 1, M8, 0);
    chk("rst_tail lval", 32'(o_lval), 0);
    step(0, 0, 0, 1, M8, 0);
    chk("rst_low fval", 32'(o_fval), 0);
    chk("rst_low busy", 32'(o_busy), 0);
    step(0, 1, 0, 1, M8, 0);
    chk("rst_new fval", 32'(o_fval), 1);
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 1, 1, M8, 10'(4 * k));
      chk("rst_new lval", 32'(o_lval), 32'(k == 4));
      if (k == 4) chk("rst_new data", ov_pix_data, 32'h04030201);
    end
    step(0, 1, 0, 1, M8, 0);
    step(0, 0, 0, 1, M8, 0);
    step(0, 0, 0, 1, M8, 0);
    chk("rst_end fval", 32'(o_fval), 0);

`ifdef PIX_PACK_STAT_EN
    // 2 lines x 5 Mono8 pixels: 4 words, 2 flushes
    step(0, 1, 0, 1, M8, 0);
    for (int l = 0; l < 2; l++) begin
      for (int k = 1; k <= 5; k++) step(0, 1, 1, 1, M8, 10'(4 * k));
      step(0, 1, 0, 1, M8, 0);
      step(0, 1, 0, 1, M8, 0);
    end
    step(0, 0, 0, 1, M8, 0);
    chk("stat words", 32'(ov_word_cnt), 4);
    chk("stat flush", 32'(ov_flush_cnt), 2);
    chk("stat err", 32'(ov_err_cnt), 0);
    step(0, 0, 0, 1, M8, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
